// File: rtl/mmio_pwm_ctrl.sv
// mmio_pwm_ctrl
// Memory-mapped LED and PWM controller on the CPU data bus.
// Stores and loads to a 256-byte window select a small register file. The
// N_CH PWM channels share one prescaler and one period counter. PERIOD and
// DUTY are double-buffered: software writes land in shadow registers, and the
// active copies are reloaded only at a period wrap, or every cycle while idle.
//
// Ports
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-low reset
//   MemWrite   in   1     CPU store strobe
//   DataAdr    in   32    CPU byte address; bits [1:0] are ignored
//   WriteData  in   32    store data
//   sel        out  1     combinational window hit
//   ReadData   out  32    combinational read data; 0 outside the window
//   leds       out  4     registered LED outputs
//   pwm_out    out  N_CH  registered PWM outputs
//
// Word offsets: 0x00 CTRL {PRESCALE[15:8], EN[0]}, 0x04 PERIOD, 0x08 LEDS,
// 0x0C STATUS {CNT[15:8], PEND[0]} (read-only), 0x10+4*i DUTY[i].
module mmio_pwm_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          N_CH      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic [31:0]     DataAdr,
  input  logic [31:0]     WriteData,
  output logic            sel,
  output logic [31:0]     ReadData,
  output logic [3:0]      leds,
  output logic [N_CH-1:0] pwm_out
);

  localparam logic [5:0] OFF_CTRL   = 6'd0;
  localparam logic [5:0] OFF_PERIOD = 6'd1;
  localparam logic [5:0] OFF_LEDS   = 6'd2;
  localparam logic [5:0] OFF_STATUS = 6'd3;
  localparam logic [5:0] OFF_DUTY0  = 6'd4;
  localparam logic [5:0] DUTY_END   = 6'(4 + N_CH);

  // Bus decode
  logic            sel_s;
  logic [5:0]      word_s;
  logic [5:0]      duty_off_s;
  logic [2:0]      duty_idx_s;
  logic            is_duty_s;
  logic            wr_s;
  logic            shadow_wr_s;
  logic            en_clr_s;
  logic [31:0]     rdata_s;
  logic            unused_s;

  // Engine control
  logic            tick_s;
  logic            wrap_s;
  logic            load_s;
  logic [N_CH-1:0] pwm_next_s;

  // Register file
  logic            en_r;
  logic [7:0]      prescale_r;
  logic [7:0]      period_sh_r;
  logic [3:0]      leds_r;
  logic [7:0]      duty_sh_r [8];

  // Engine state
  logic [7:0]      period_act_r;
  logic [7:0]      duty_act_r [N_CH];
  logic [7:0]      ps_r;
  logic [7:0]      cnt_r;
  logic            pend_r;
  logic [N_CH-1:0] pwm_r;

  assign sel_s       = (DataAdr[31:8] == BASE_ADDR[31:8]);
  assign word_s      = DataAdr[7:2];
  assign duty_off_s  = word_s - OFF_DUTY0;
  assign duty_idx_s  = duty_off_s[2:0];
  assign is_duty_s   = (word_s >= OFF_DUTY0) && (word_s < DUTY_END);
  assign wr_s        = MemWrite && sel_s;
  assign shadow_wr_s = wr_s && ((word_s == OFF_PERIOD) || is_duty_s);
  // A CTRL store with EN=0 stops the engine at that very edge rather than
  // waiting for en_r to fall.
  assign en_clr_s    = wr_s && (word_s == OFF_CTRL) && !WriteData[0];

  assign tick_s = en_r && (ps_r == prescale_r);
  assign wrap_s = tick_s && (cnt_r == period_act_r);
  // Idle keeps the active copies tracking the shadows every cycle.
  assign load_s = !en_r || wrap_s;

  assign unused_s = ^{DataAdr[1:0], WriteData[31:16], duty_off_s[5:3]};

  assign sel      = sel_s;
  assign ReadData = rdata_s;
  assign leds     = leds_r;
  assign pwm_out  = pwm_r;

  // Read mux for the single-cycle CPU load path
  always_comb begin
    rdata_s = 32'd0;
    if (sel_s) begin
      case (word_s)
        OFF_CTRL:   rdata_s = {16'd0, prescale_r, 7'd0, en_r};
        OFF_PERIOD: rdata_s = {24'd0, period_sh_r};
        OFF_LEDS:   rdata_s = {28'd0, leds_r};
        OFF_STATUS: rdata_s = {16'd0, cnt_r, 7'd0, pend_r};
        default: begin
          if (is_duty_s) begin
            rdata_s = {24'd0, duty_sh_r[duty_idx_s]};
          end else begin
            rdata_s = 32'd0;
          end
        end
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Next PWM levels from the current-cycle count and active duties
  always_comb begin
    pwm_next_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      pwm_next_s[i] = en_r && !en_clr_s && (cnt_r < duty_act_r[i]);
    end
  end

  // CPU-writable registers: CTRL, PERIOD shadow, LEDS, DUTY shadows
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r        <= 1'b0;
      prescale_r  <= 8'd0;
      period_sh_r <= 8'd0;
      leds_r      <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        duty_sh_r[i] <= 8'd0;
      end
    end else if (wr_s) begin
      case (word_s)
        OFF_CTRL: begin
          en_r       <= WriteData[0];
          prescale_r <= WriteData[15:8];
        end
        OFF_PERIOD: period_sh_r <= WriteData[7:0];
        OFF_LEDS:   leds_r      <= WriteData[3:0];
        default: begin
          if (is_duty_s) begin
            duty_sh_r[duty_idx_s] <= WriteData[7:0];
          end
        end
      endcase
    end
  end

  // Prescaler and period counter; both held at 0 while stopped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_r  <= 8'd0;
      cnt_r <= 8'd0;
    end else if (!en_r || en_clr_s) begin
      ps_r  <= 8'd0;
      cnt_r <= 8'd0;
    end else if (tick_s) begin
      ps_r  <= 8'd0;
      cnt_r <= wrap_s ? 8'd0 : cnt_r + 8'd1;
    end else begin
      ps_r <= ps_r + 8'd1;
    end
  end

  // Active PERIOD/DUTY copies; a coincident store is seen only next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_act_r <= 8'd0;
      for (int i = 0; i < N_CH; i++) begin
        duty_act_r[i] <= 8'd0;
      end
    end else if (load_s) begin
      period_act_r <= period_sh_r;
      for (int i = 0; i < N_CH; i++) begin
        duty_act_r[i] <= duty_sh_r[i];
      end
    end
  end

  // PEND: set by shadow stores (wins over a coincident wrap), cleared on wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= 1'b0;
    end else if (!en_r) begin
      pend_r <= 1'b0;
    end else if (shadow_wr_s) begin
      pend_r <= 1'b1;
    end else if (wrap_s) begin
      pend_r <= 1'b0;
    end
  end

  // Registered PWM outputs, one clk behind the counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_r <= {N_CH{1'b0}};
    end else begin
      pwm_r <= pwm_next_s;
    end
  end

endmodule

// File: tb/tb_mmio_pwm_ctrl.sv
module tb_mmio_pwm_ctrl;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [31:0]   DataAdr;
  logic [31:0]   WriteData;
  logic          sel;
  logic [31:0]   ReadData;
  logic [3:0]    leds;
  logic [N-1:0]  pwm_out;

  int total = 0;
  int bad   = 0;

  mmio_pwm_ctrl #(.BASE_ADDR(BASE), .N_CH(N)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .sel(sel), .ReadData(ReadData), .leds(leds),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Reference model state, advanced once per rising edge from the rules
  bit           m_en, m_pend, m_wrap_last;
  logic [7:0]   m_pre, m_per, m_pera, m_ps, m_cnt;
  logic [7:0]   m_duty [N];
  logic [7:0]   m_dutya [N];
  logic [3:0]   m_leds;
  logic [N-1:0] m_pwm;

  function automatic void m_reset();
    m_en = 1'b0; m_pend = 1'b0; m_wrap_last = 1'b0;
    m_pre = 8'd0; m_per = 8'd0; m_pera = 8'd0; m_ps = 8'd0; m_cnt = 8'd0;
    m_leds = 4'd0; m_pwm = '0;
    for (int i = 0; i < N; i++) begin
      m_duty[i] = 8'd0;
      m_dutya[i] = 8'd0;
    end
  endfunction

  function automatic void m_edge();
    bit hit, w, tick, wrap, clr, shw;
    int idx;
    hit  = (DataAdr[31:8] == BASE[31:8]);
    w    = MemWrite && hit;
    idx  = int'(DataAdr[7:2]);
    tick = m_en && (m_ps == m_pre);
    wrap = tick && (m_cnt == m_pera);
    clr  = w && (idx == 0) && !WriteData[0];
    shw  = w && ((idx == 1) || (idx >= 4 && idx < 4 + N));
    for (int i = 0; i < N; i++) m_pwm[i] = m_en && !clr && (m_cnt < m_dutya[i]);
    if (!m_en) m_pend = 1'b0;
    else if (shw) m_pend = 1'b1;
    else if (wrap) m_pend = 1'b0;
    if (!m_en || wrap) begin
      m_pera = m_per;
      for (int i = 0; i < N; i++) m_dutya[i] = m_duty[i];
    end
    if (!m_en || clr) begin
      m_ps = 8'd0; m_cnt = 8'd0;
    end else if (tick) begin
      m_ps = 8'd0;
      m_cnt = wrap ? 8'd0 : m_cnt + 8'd1;
    end else begin
      m_ps = m_ps + 8'd1;
    end
    m_wrap_last = wrap;
    if (w) begin
      if (idx == 0) begin m_en = WriteData[0]; m_pre = WriteData[15:8]; end
      else if (idx == 1) m_per = WriteData[7:0];
      else if (idx == 2) m_leds = WriteData[3:0];
      else if (idx >= 4 && idx < 4 + N) m_duty[idx-4] = WriteData[7:0];
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w;
    if (a[31:8] != BASE[31:8]) return 32'd0;
    w = int'(a[7:2]);
    if (w == 0) return {16'd0, m_pre, 7'd0, m_en};
    if (w == 1) return {24'd0, m_per};
    if (w == 2) return {28'd0, m_leds};
    if (w == 3) return {16'd0, m_cnt, 7'd0, m_pend};
    if (w >= 4 && w < 4 + N) return {24'd0, m_duty[w-4]};
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later
  task automatic step();
    @(posedge clk);
    if (reset) m_edge();
    #1;
    chk("pwm", 32'(pwm_out), 32'(m_pwm));
    chk("leds", 32'(leds), 32'(m_leds));
  endtask

  task automatic wr_abs(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    step();
    MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    wr_abs(BASE + off, d);
  endtask

  task automatic rd(input logic [31:0] off, input string tag);
    MemWrite = 1'b0; DataAdr = BASE + off;
    #1;
    chk(tag, ReadData, m_read(DataAdr));
    chk("sel", 32'(sel), 32'd1);
  endtask

  task automatic count_hi(input int ch, input int n, output int hc);
    hc = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_out[ch]) hc++;
      step();
    end
  endtask

  initial begin
    int hc, h1, h2;
    bit found;
    logic [31:0] a;

    reset = 1'b0; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    reset = 1'b1;

    // All offsets read 0 after reset; outside the window sel=0, data=0
    for (int o = 0; o < 16; o++) begin
      rd(32'(o * 4), "rd_after_reset");
      chk("rd_zero", ReadData, 32'd0);
      step();
    end
    DataAdr = 32'h0000_0008; #1;
    chk("miss_sel", 32'(sel), 32'd0);
    chk("miss_data", ReadData, 32'd0);
    wr(32'h08, 32'h0000_000A);
    chk("leds_a", 32'(leds), 32'hA);
    rd(32'h08, "rd_leds");
    chk("rd_leds_a", ReadData, 32'hA);

    // PRESCALE=0, PERIOD=9, DUTY0=3: 3 of every 10 clocks high
    wr(32'h04, 32'd9);
    wr(32'h10, 32'd3);
    wr(32'h00, 32'h0000_0001);
    chk("before_first", 32'(pwm_out[0]), 32'd0);
    step();
    chk("first_high", 32'(pwm_out[0]), 32'd1);
    for (int f = 0; f < 3; f++) begin
      count_hi(0, 10, hc);
      chk("duty3_frame", 32'(hc), 32'd3);
    end

    // Mid-frame duty update waits for the wrap
    repeat (4) step();
    wr(32'h10, 32'd7);
    rd(32'h0C, "status_pend");
    chk("pend_set", 32'(ReadData[0]), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_wrap_last) found = 1'b1;
    end
    chk("wrap_seen", 32'(found), 32'd1);
    rd(32'h0C, "status_after_wrap");
    chk("pend_clr", 32'(ReadData[0]), 32'd0);
    count_hi(0, 10, hc);
    chk("duty7_frame", 32'(hc), 32'd7);

    // Store DUTY0 on the exact wrap edge
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_en && m_ps == m_pre && m_cnt == m_pera) found = 1'b1;
      else step();
    end
    chk("wrap_cycle_seen", 32'(found), 32'd1);
    wr(32'h10, 32'd2);
    rd(32'h0C, "status_wrapwr");
    chk("pend_wrapwr", 32'(ReadData[0]), 32'd1);
    count_hi(0, 10, hc);
    chk("old_duty_kept", 32'(hc), 32'd7);
    count_hi(0, 10, hc);
    chk("new_duty_next", 32'(hc), 32'd2);

    // EN cleared mid-period, then PRESCALE=3, PERIOD=4 with edge duties
    repeat (3) step();
    wr(32'h00, 32'd0);
    chk("en_clr_pwm", 32'(pwm_out), 32'd0);
    rd(32'h0C, "status_stopped");
    chk("cnt_stopped", ReadData, 32'd0);
    wr(32'h04, 32'd4);
    wr(32'h14, 32'd0);
    wr(32'h18, 32'd5);
    wr(32'h10, 32'd3);
    wr(32'h00, 32'h0000_0301);
    step();
    hc = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (pwm_out[0]) hc++;
      if (pwm_out[1]) h1++;
      if (pwm_out[2]) h2++;
      step();
    end
    chk("ps3_ch0", 32'(hc), 32'd24);
    chk("ps3_ch1_low", 32'(h1), 32'd0);
    chk("ps3_ch2_high", 32'(h2), 32'd40);

    // Randomized register traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0: wr(32'h00, {16'd0, 8'($urandom_range(0, 2)), 7'd0, 1'($urandom_range(0, 3) != 0)});
        1: wr(32'h04, 32'($urandom_range(0, 12)));
        2, 3: wr(32'h10 + 32'($urandom_range(0, N - 1) * 4), 32'($urandom_range(0, 14)));
        4: wr(32'h08, $urandom);
        5: begin
          if ($urandom_range(0, 1) == 0) a = BASE + 32'($urandom_range(8, 15) * 4);
          else a = $urandom & 32'h7FFF_FFFF;
          wr_abs(a, $urandom);
        end
        6: begin
          rd(32'($urandom_range(0, 15) * 4), "rd_rand");
          step();
        end
        default: step();
      endcase
    end

    // Reset pulse mid-frame
    wr(32'h00, 32'h0000_0001);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("async_pwm", 32'(pwm_out), 32'd0);
    chk("async_leds", 32'(leds), 32'd0);
    m_reset();
    step();
    reset = 1'b1;
    rd(32'h00, "ctrl_after_reset");
    chk("ctrl_zero", ReadData, 32'd0);
    step();
    for (int o = 1; o < 8; o++) begin
      rd(32'(o * 4), "rd_post_reset");
      step();
    end
    wr(32'h30, 32'hFFFF_FFFF);
    rd(32'h30, "unmapped");
    chk("unmapped_zero", ReadData, 32'd0);
    step();
    for (int o = 0; o < 8; o++) begin
      rd(32'(o * 4), "rd_after_unmapped");
      step();
    end
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
